// File: rtl/iic_target.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match, byte RX/TX with host handshake.
// Define IIC_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizers.
module iic_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] own_addr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       selected,
    output logic       rw,
    output logic       busy,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        AACK   = 3'd2,
        RX     = 3'd3,
        RACK   = 3'd4,
        TX     = 3'd5,
        TACK   = 3'd6,
        IGNORE = 3'd7
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_p;
    logic                   sda_p;

    // Synchronizers reset to the idle-bus level so release from reset creates no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef IIC_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_w;
    logic [1:0] sda_w;
    logic       scl_maj;
    logic       sda_maj;

    always_comb begin
        scl_maj = (scl_sync[SYNC_STAGES-1] & scl_w[0]) | (scl_sync[SYNC_STAGES-1] & scl_w[1]) |
                  (scl_w[0] & scl_w[1]);
        sda_maj = (sda_sync[SYNC_STAGES-1] & sda_w[0]) | (sda_sync[SYNC_STAGES-1] & sda_w[1]) |
                  (sda_w[0] & sda_w[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_w <= '1;
            sda_w <= '1;
            scl_s <= 1'b1;
            sda_s <= 1'b1;
        end else begin
            scl_w <= {scl_w[0], scl_sync[SYNC_STAGES-1]};
            sda_w <= {sda_w[0], sda_sync[SYNC_STAGES-1]};
            scl_s <= scl_maj;
            sda_s <= sda_maj;
        end
    end
`else
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_s;
            sda_p <= sda_s;
        end
    end

    logic start_ev;
    logic stop_ev;
    logic scl_r;
    logic scl_f;

    assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_ev  = scl_s & scl_p & ~sda_p & sda_s;
    assign scl_r    = scl_s & ~scl_p;
    assign scl_f    = ~scl_s & scl_p;

    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic [6:0] addr_q;
    // byte_done marks "8th bit (or ACK) sampled, act on the next SCL fall"
    logic       byte_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            selected  <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            shift     <= 8'h00;
            bit_cnt   <= 3'd7;
            addr_q    <= 7'h00;
            byte_done <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            if (stop_ev) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                selected  <= 1'b0;
                busy      <= 1'b0;
                byte_done <= 1'b0;
            end else if (start_ev) begin
                state     <= ADDR;
                sda_oe    <= 1'b0;
                selected  <= 1'b0;
                busy      <= 1'b1;
                bit_cnt   <= 3'd7;
                byte_done <= 1'b0;
                addr_q    <= own_addr;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_r) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) byte_done <= 1'b1;
                        end else if (scl_f && byte_done) begin
                            byte_done <= 1'b0;
                            // General call (address 0) is deliberately never acknowledged.
                            if (shift[7:1] == addr_q && addr_q != 7'h00) begin
                                state  <= AACK;
                                sda_oe <= 1'b1;
                                rw     <= shift[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    AACK: begin
                        if (scl_f) begin
                            selected <= 1'b1;
                            bit_cnt  <= 3'd7;
                            if (rw) begin
                                state   <= TX;
                                tx_load <= 1'b1;
                                shift   <= tx_data;
                                sda_oe  <= ~tx_data[7];
                            end else begin
                                state  <= RX;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RX: begin
                        if (scl_r) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                rx_data   <= {shift[6:0], sda_s};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_f && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= RACK;
                        end
                    end
                    RACK: begin
                        if (scl_f) begin
                            sda_oe <= 1'b0;
                            state  <= RX;
                        end
                    end
                    TX: begin
                        if (scl_f) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= TACK;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                shift   <= {shift[6:0], 1'b0};
                                sda_oe  <= ~shift[6];
                            end
                        end
                    end
                    TACK: begin
                        if (scl_r) begin
                            if (sda_s) begin
                                state  <= IGNORE;
                                sda_oe <= 1'b0;
                            end else begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_f && byte_done) begin
                            byte_done <= 1'b0;
                            tx_load   <= 1'b1;
                            shift     <= tx_data;
                            sda_oe    <= ~tx_data[7];
                            bit_cnt   <= 3'd7;
                            state     <= TX;
                        end
                    end
                    IGNORE: sda_oe <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: a bit-banged I2C controller model drives the bus, monitors
// collect rx bytes and tx_load pulses, and each scenario task checks its own results.
`timescale 1ns/1ps
module tb_iic_target;
    localparam int Q = 10;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_RX     = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic [6:0] own_addr = 7'h50;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       selected;
    logic       rw;
    logic       busy;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int tx_loads = 0;
    int oe_cycles = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] tx_q[$];

    // Open-drain bus: either side pulling low wins.
    assign sda_line = sda_m & ~sda_oe;

    iic_target #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
        .own_addr(own_addr), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_load(tx_load), .selected(selected), .rw(rw), .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) got_q.push_back(rx_data);
        if (sda_oe) oe_cycles++;
        if (tx_load) begin
            tx_loads++;
            if (tx_q.size() > 0) tx_data = tx_q.pop_front();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_line; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load: got %b expected 0", tx_load); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        rst_n = 1'b1;
        tick(5);
        checks++; if (selected !== 1'b0) begin errors++; $display("FAIL reset_selected: got %b expected 0", selected); end
        checks++; if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b expected 0", rw); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0] data [3] = '{8'h3C, 8'h81, 8'h7E};
        got_q.delete();
        exp_q.delete();
        i2c_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_start: got %b expected 1", busy); end
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b expected 0", ack); end
        checks++; if (selected !== 1'b1 || rw !== 1'b0) begin errors++; $display("FAIL write_sel_rw: got %b/%b expected 1/0", selected, rw); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(data[i]);
            write_byte(data[i], ack);
            checks++; if (ack !== 1'b0) begin errors++; $display("FAIL write_data_ack%0d: got %b expected 0", i, ack); end
        end
        i2c_stop();
        tick(5);
        checks++; if (busy !== 1'b0 || selected !== 1'b0) begin errors++; $display("FAIL write_stop: busy/selected %b/%b expected 0/0", busy, selected); end
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL write_rx_count: got %0d expected 3", got_q.size()); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL write_rx_byte: got none expected %h", e); end
            else begin
                logic [7:0] g;
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL write_rx_byte: got %h expected %h", g, e); end
            end
        end
    endtask

    task automatic test_mismatch();
        logic ack;
        got_q.delete();
        oe_cycles = 0;
        i2c_start();
        write_byte(8'h50, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mis_addr_ack: got %b expected 1", ack); end
        write_byte(8'hFF, ack);
        checks++; if (state_dbg !== S_IGNORE) begin errors++; $display("FAIL mis_state: got %0d expected %0d", state_dbg, S_IGNORE); end
        i2c_stop();
        tick(5);
        checks++; if (oe_cycles != 0) begin errors++; $display("FAIL mis_sda_oe: got %0d cycles expected 0", oe_cycles); end
        checks++; if (selected !== 1'b0) begin errors++; $display("FAIL mis_selected: got %b expected 0", selected); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mis_rx_count: got %0d expected 0", got_q.size()); end
        i2c_start();
        write_byte(8'h00, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL gencall_ack: got %b expected 1", ack); end
        i2c_stop();
        tick(5);
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] d;
        tx_loads = 0;
        tx_q.delete();
        tx_data = 8'h5A;
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'h00);
        i2c_start();
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b expected 0", ack); end
        checks++; if (selected !== 1'b1 || rw !== 1'b1) begin errors++; $display("FAIL read_sel_rw: got %b/%b expected 1/1", selected, rw); end
        read_byte(d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL read_byte0: got %h expected 5a", d); end
        write_bit(1'b0);
        read_byte(d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL read_byte1: got %h expected c3", d); end
        write_bit(1'b1);
        tick(5);
        checks++; if (sda_oe !== 1'b0 || state_dbg !== S_IGNORE) begin errors++; $display("FAIL read_nack: sda_oe/state %b/%0d expected 0/%0d", sda_oe, state_dbg, S_IGNORE); end
        checks++; if (tx_loads != 2) begin errors++; $display("FAIL read_tx_loads: got %0d expected 2", tx_loads); end
        i2c_stop();
        tick(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_rep_start();
        logic ack;
        logic [7:0] d;
        logic [3:0] part = 4'b1011;
        got_q.delete();
        tx_q.delete();
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_addr_ack: got %b expected 0", ack); end
        for (int i = 3; i >= 0; i--) write_bit(part[i]);
        i2c_start();
        checks++; if (selected !== 1'b0 || state_dbg !== S_ADDR) begin errors++; $display("FAIL rs_restart: sel/state %b/%0d expected 0/%0d", selected, state_dbg, S_ADDR); end
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rs_read_ack: got %b expected 0", ack); end
        checks++; if (selected !== 1'b1 || rw !== 1'b1) begin errors++; $display("FAIL rs_sel_rw: got %b/%b expected 1/1", selected, rw); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rs_partial_rx: got %0d bytes expected 0", got_q.size()); end
        read_byte(d);
        checks++; if (d !== 8'h96) begin errors++; $display("FAIL rs_read_byte: got %h expected 96", d); end
        write_bit(1'b1);
        i2c_stop();
        tick(5);
    endtask

    task automatic test_reset_mid();
        logic ack;
        logic [7:0] a = 8'hA0;
        got_q.delete();
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        sda_m = 1'b1;
        tick(Q);
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rstmid_ack_drive: got %b expected 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_release: got %b expected 0", sda_oe); end
        tick(3);
        rst_n = 1'b1;
        tick(5);
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_ignored: ack/busy %b/%b expected 1/0", ack, busy); end
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h55, ack);
        i2c_stop();
        tick(5);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
            errors++; $display("FAIL rstmid_recover: got %0d bytes first %h expected 1 byte 55", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
        end
    endtask

    task automatic test_glitch();
        logic ack;
        logic [7:0] d = 8'hA5;
        got_q.delete();
        i2c_start();
        write_byte(8'hA0, ack);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(1);
        sda_m = 1'b1; tick(Q - 1);
        scl_m = 1'b0; tick(Q);
`ifdef IIC_TARGET_GLITCH_FILTER_EN
        checks++; if (busy !== 1'b1 || state_dbg !== S_RX) begin errors++; $display("FAIL glitch_filtered: busy/state %b/%0d expected 1/%0d", busy, state_dbg, S_RX); end
`else
        checks++; if (busy !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL glitch_stop: busy/state %b/%0d expected 0/%0d", busy, state_dbg, S_IDLE); end
`endif
        for (int i = 6; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
`ifdef IIC_TARGET_GLITCH_FILTER_EN
        checks++; if (ack !== 1'b0 || got_q.size() != 1) begin errors++; $display("FAIL glitch_byte: ack/bytes %b/%0d expected 0/1", ack, got_q.size()); end
        else begin
            checks++; if (got_q[0] !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %h expected a5", got_q[0]); end
        end
`else
        checks++; if (ack !== 1'b1 || got_q.size() != 0) begin errors++; $display("FAIL glitch_discard: ack/bytes %b/%0d expected 1/0", ack, got_q.size()); end
`endif
        i2c_stop();
        tick(5);
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_rep_start();
        test_reset_mid();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
